// File: rtl/wb_bus_pkg.sv
// Shared types and defaults for the Wishbone shared-bus interconnect.
package wb_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

    localparam int TCNT_W = 16;

    // Slave 0 (RAM) sits in the LSBs, then UART, then GPIO.
    localparam logic [3*32-1:0] DEF_SLAVE_BASE = {32'h2000_0000, 32'h1000_0000, 32'h8000_0000};
    localparam logic [3*32-1:0] DEF_SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000};

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin pick: the requester nearest after last_i (cyclic) wins, one-hot out.
module wb_rr_arbiter #(
    parameter int NM = 2,
    localparam int LW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [LW-1:0] last_i,
    output logic [NM-1:0] grant_o
);

    logic          found;
    logic [LW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NM; k++) begin
            idx = LW'((int'(last_i) + k) % NM);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_shared_bus.sv
// Wishbone B4 classic shared bus: NM masters, NS slaves, round-robin per bus
// cycle, base/mask decode, error on unmapped addresses and on slave timeout.
module wb_shared_bus
    import wb_bus_pkg::*;
#(
    parameter int                NM         = 2,
    parameter int                NS         = 3,
    parameter int                AW         = 32,
    parameter int                DW         = 32,
    parameter logic [NS*AW-1:0]  SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NS*AW-1:0]  SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int                TIMEOUT    = 255,
    localparam int               SW         = DW / 8,
    localparam int               LW         = (NM > 1) ? $clog2(NM) : 1,
    localparam int               SLW        = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NM*AW-1:0] m_adr_i,
    input  logic [NM*DW-1:0] m_dat_i,
    input  logic [NM*SW-1:0] m_sel_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_cyc_i,
    input  logic [NM-1:0]    m_stb_i,
    output logic [DW-1:0]    m_dat_o,
    output logic [NM-1:0]    m_ack_o,
    output logic [NM-1:0]    m_err_o,
    output logic [AW-1:0]    s_adr_o,
    output logic [DW-1:0]    s_dat_o,
    output logic [SW-1:0]    s_sel_o,
    output logic             s_we_o,
    output logic [NS-1:0]    s_cyc_o,
    output logic [NS-1:0]    s_stb_o,
    input  logic [NS*DW-1:0] s_dat_i,
    input  logic [NS-1:0]    s_ack_i,
    input  logic [NS-1:0]    s_err_i
);

    localparam logic [TCNT_W-1:0] TO_VAL = TCNT_W'(TIMEOUT);

    bus_state_e        state_q, state_d;
    logic [NM-1:0]     grant_q, grant_d;
    logic [LW-1:0]     last_q, last_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              unm_err_q, unm_err_d;

    logic [NM-1:0]     arb_grant;
    logic [LW-1:0]     arb_idx;
    logic [LW-1:0]     gidx;
    logic              busy, g_cyc, g_stb;
    logic [AW-1:0]     g_adr;
    logic              hit;
    logic [SLW-1:0]    sidx;
    logic              stall, to_fire;

    wb_rr_arbiter #(.NM(NM)) u_arb (
        .req_i   (m_cyc_i),
        .last_i  (last_q),
        .grant_o (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        gidx    = '0;
        for (int m = 0; m < NM; m++) begin
            if (arb_grant[m]) arb_idx = LW'(m);
            if (grant_q[m])   gidx    = LW'(m);
        end
    end

    assign busy  = (state_q == BUSY);
    assign g_cyc = busy & m_cyc_i[gidx];
    assign g_stb = busy & m_stb_i[gidx];
    assign g_adr = busy ? m_adr_i[gidx*AW +: AW] : '0;

    assign s_adr_o = g_adr;
    assign s_dat_o = busy ? m_dat_i[gidx*DW +: DW] : '0;
    assign s_sel_o = busy ? m_sel_i[gidx*SW +: SW] : '0;
    assign s_we_o  = busy & m_we_i[gidx];

    // Descending scan so the lowest-indexed matching slave wins.
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int s = NS - 1; s >= 0; s--) begin
            if ((g_adr & SLAVE_MASK[s*AW +: AW]) == SLAVE_BASE[s*AW +: AW]) begin
                hit  = 1'b1;
                sidx = SLW'(s);
            end
        end
    end

    assign to_fire   = g_cyc & g_stb & hit & (tcnt_q == TO_VAL);
    assign stall     = g_cyc & g_stb & hit & ~s_ack_i[sidx] & ~s_err_i[sidx];
    assign tcnt_d    = (to_fire || !stall) ? '0 : tcnt_q + TCNT_W'(1);
    assign unm_err_d = g_cyc & g_stb & ~hit & ~unm_err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    state_d = BUSY;
                    grant_d = arb_grant;
                    last_d  = arb_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: a transfer is live while cyc&stb are high; the cycle in which
    // ack or err is seen completes it, and stb still high after that starts a new one.
    always_comb begin
        s_cyc_o = '0;
        s_stb_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_dat_o = '0;
        if (g_cyc && hit) begin
            s_cyc_o[sidx] = 1'b1;
            s_stb_o[sidx] = g_stb & ~to_fire;
            m_ack_o[gidx] = s_ack_i[sidx] & ~to_fire;
            m_err_o[gidx] = (s_err_i[sidx] & ~to_fire) | to_fire;
            m_dat_o       = s_dat_i[sidx*DW +: DW];
        end
        if (busy && unm_err_q) m_err_o[gidx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LW'(NM - 1);
            tcnt_q    <= '0;
            unm_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            tcnt_q    <= tcnt_d;
            unm_err_q <= unm_err_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Directed bench for wb_shared_bus: two masters, RAM/UART/GPIO slaves, short timeout.
module tb_wb_shared_bus;

    localparam int NM = 2;
    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic             clk;
    logic             reset;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat;
    logic [NM*SW-1:0] m_sel;
    logic [NM-1:0]    m_we, m_cyc, m_stb;
    logic [DW-1:0]    m_dat_o;
    logic [NM-1:0]    m_ack_o, m_err_o;
    logic [AW-1:0]    s_adr_o;
    logic [DW-1:0]    s_dat_o;
    logic [SW-1:0]    s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_cyc_o, s_stb_o;
    logic [NS*DW-1:0] s_dat;
    logic [NS-1:0]    s_ack, s_err;

    int n_checks = 0;
    int n_fail   = 0;

    wb_shared_bus #(
        .NM(NM), .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_dat_o (m_dat_o),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_dat_i (s_dat),
        .s_ack_i (s_ack),
        .s_err_i (s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_master(input int m, input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc[m]          = cyc;
        m_stb[m]          = stb;
        m_we[m]           = we;
        m_adr[m*AW +: AW] = adr;
        m_dat[m*DW +: DW] = dat;
        m_sel[m*SW +: SW] = sel;
    endtask

    task automatic idle_all();
        m_adr = '0; m_dat = '0; m_sel = '0;
        m_we  = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0; s_ack = '0; s_err = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        idle_all();
        do_reset();

        // Reset state, held in IDLE
        #1;
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_m_ack", 32'(m_ack_o), 32'h0);
        check("rst_m_err", 32'(m_err_o), 32'h0);
        check("rst_m_dat", m_dat_o, 32'h0);
        check("rst_s_adr", s_adr_o, 32'h0);

        // Master 0 reads RAM, ack on the second BUSY cycle
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
        #1;
        check("rd_arb_stb", 32'(s_stb_o), 32'h0);
        cycle();
        check("rd_s_stb", 32'(s_stb_o), 32'h1);
        check("rd_s_cyc", 32'(s_cyc_o), 32'h1);
        check("rd_s_adr", s_adr_o, 32'h8000_0010);
        check("rd_wait_ack", 32'(m_ack_o), 32'h0);
        cycle();
        s_ack[0] = 1'b1;
        s_dat[0*DW +: DW] = 32'hDEAD_BEEF;
        #1;
        check("rd_ack", 32'(m_ack_o), 32'h1);
        check("rd_dat", m_dat_o, 32'hDEAD_BEEF);
        cycle();
        s_ack = '0;
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rd_drop_cyc", 32'(s_cyc_o), 32'h0);
        check("rd_late_ack", 32'(m_ack_o), 32'h0);
        cycle();
        check("rd_idle_adr", s_adr_o, 32'h0);

        // Simultaneous request after reset: master 0 first, then master 1
        do_reset();
        drive_master(0, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0);
        drive_master(1, 1'b1, 1'b0, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
        cycle();
        check("rr_first_cyc", 32'(s_cyc_o), 32'h1);
        check("rr_first_adr", s_adr_o, 32'h8000_0000);
        cycle();
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("rr_drop_cyc", 32'(s_cyc_o), 32'h0);
        cycle();
        check("rr_arb_cyc", 32'(s_cyc_o), 32'h0);
        cycle();
        check("rr_second_cyc", 32'(s_cyc_o), 32'h2);
        check("rr_second_adr", s_adr_o, 32'h1000_0000);
        cycle();

        // Master 1 writes GPIO within the same held cyc
        drive_master(1, 1'b1, 1'b1, 1'b1, 32'h2000_0000, 32'h0000_00A5, 4'b0001);
        #1;
        check("wr_s_cyc", 32'(s_cyc_o), 32'h4);
        check("wr_s_stb", 32'(s_stb_o), 32'h4);
        check("wr_s_we", 32'(s_we_o), 32'h1);
        check("wr_s_dat", s_dat_o, 32'h0000_00A5);
        check("wr_s_sel", 32'(s_sel_o), 32'h1);
        check("wr_no_ack", 32'(m_ack_o), 32'h0);
        cycle();
        s_ack[2] = 1'b1;
        #1;
        check("wr_ack", 32'(m_ack_o), 32'h2);
        cycle();
        s_ack = '0;
        drive_master(1, 1'b1, 1'b0, 1'b0, 32'h2000_0000, 32'h0, 4'h0);
        #1;
        check("wr_ack_gone", 32'(m_ack_o), 32'h0);
        drive_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();

        // Unmapped address: no slave cycle, single registered error pulse
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        cycle();
        check("unm_s_cyc", 32'(s_cyc_o), 32'h0);
        check("unm_err_early", 32'(m_err_o), 32'h0);
        cycle();
        check("unm_err_pulse", 32'(m_err_o), 32'h1);
        drive_master(0, 1'b1, 1'b0, 1'b0, 32'h4000_0000, 32'h0, 4'hF);
        cycle();
        check("unm_err_single", 32'(m_err_o), 32'h0);
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();

        // UART never acks: four stalled cycles, then error with strobe masked
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'hF);
        cycle();
        for (int i = 0; i < 4; i++) begin
            check("to_stall_stb", 32'(s_stb_o), 32'h2);
            check("to_stall_err", 32'(m_err_o), 32'h0);
            cycle();
        end
        check("to_fire_err", 32'(m_err_o), 32'h1);
        check("to_fire_stb", 32'(s_stb_o), 32'h0);
        check("to_fire_cyc", 32'(s_cyc_o), 32'h2);
        cycle();
        check("to_restart_stb", 32'(s_stb_o), 32'h2);
        check("to_restart_err", 32'(m_err_o), 32'h0);
        drive_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        cycle();
        cycle();

        // Reset during a stalled RAM cycle, then master 0 wins after release
        drive_master(1, 1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'hF);
        cycle();
        check("mr_busy_stb", 32'(s_stb_o), 32'h1);
        reset = 1'b1;
        cycle();
        check("mr_s_cyc", 32'(s_cyc_o), 32'h0);
        check("mr_s_stb", 32'(s_stb_o), 32'h0);
        check("mr_m_err", 32'(m_err_o), 32'h0);
        reset = 1'b0;
        drive_master(0, 1'b1, 1'b1, 1'b0, 32'h2000_0010, 32'h0, 4'hF);
        cycle();
        check("mr_regrant_cyc", 32'(s_cyc_o), 32'h4);
        check("mr_regrant_adr", s_adr_o, 32'h2000_0010);
        idle_all();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_shared_bus.md
# wb_shared_bus

Parametrised Wishbone B4 classic shared-bus interconnect connecting `NM` masters to `NS` slaves. It arbitrates round-robin per bus cycle and decodes the granted master's address against a base/mask table. It also returns an error for unmapped addresses and for slaves that fail to respond within a timeout. It replaces the fixed two-master/three-slave intercon in the SoC top level and sits between the CPU instruction and data ports and the RAM/UART/GPIO slaves.

## Interface
- `NM`, 2: number of masters (1..8); index 0 has first priority after reset.
- `NS`, 3: number of slaves (1..8).
- `AW`, 32: address width.
- `DW`, 32: data width; `SW = DW/8` select lines.
- `SLAVE_BASE`, {32'h2000_0000, 32'h1000_0000, 32'h8000_0000}: `NS*AW` packed base addresses, slave 0 in the LSBs.
- `SLAVE_MASK`, {32'hFFFF_F000, 32'hFFFF_F000, 32'hF000_0000}: `NS*AW` packed masks. A slave matches when `(adr & mask) == base`.
- `TIMEOUT`, 255: cycles of unacknowledged strobe before an error is generated (1..65535).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `m_adr_i`  in  NM*AW  master addresses.
- `m_dat_i`  in  NM*DW  master write data.
- `m_sel_i`  in  NM*SW  master byte selects.
- `m_we_i`  in  NM  master write enables.
- `m_cyc_i`  in  NM  master cycle signals.
- `m_stb_i`  in  NM  master strobes.
- `m_dat_o`  out  DW  read data, broadcast to all masters.
- `m_ack_o`  out  NM  per-master acknowledge.
- `m_err_o`  out  NM  per-master error.
- `s_adr_o`  out  AW  shared slave address.
- `s_dat_o`  out  DW  shared slave write data.
- `s_sel_o`  out  SW  shared slave byte selects.
- `s_we_o`  out  1  shared slave write enable.
- `s_cyc_o`  out  NS  per-slave cycle.
- `s_stb_o`  out  NS  per-slave strobe.
- `s_dat_i`  in  NS*DW  slave read data.
- `s_ack_i`  in  NS  slave acknowledges.
- `s_err_i`  in  NS  slave errors.

## Operation
- FSM with states IDLE and BUSY, plus registers `grant` (one-hot, NM bits), `last` (index) and `tcnt` (16 bits).
- IDLE: if any `m_cyc_i` is high, the requesting master nearest after `last` (cyclic) is registered into `grant` and the FSM moves to BUSY. `last` takes that index.
- BUSY: the granted master's adr/dat/sel/we drive the `s_*` buses combinationally.
  - Decode selects the lowest-indexed matching slave, which receives `s_cyc_o = m_cyc`. Its `s_stb_o` follows `m_stb` unless suppressed (see timeout).
  - The selected slave's ack/err/dat return to the granted master. Non-granted masters see ack=err=0.
- Unmapped address with stb high: no `s_cyc_o` is asserted. A registered one-cycle `m_err_o` pulse is issued the cycle after stb is first seen, and repeats for each new strobe.
- Timeout: `tcnt` increments each BUSY cycle with stb high and no slave ack/err, and clears on ack/err or when stb is low.
  - When `tcnt == TIMEOUT`, the interconnect pulses `m_err_o` for one cycle, forces `s_stb_o` low that cycle, and clears `tcnt`.
- BUSY returns to IDLE in the cycle after the granted master's `m_cyc_i` falls. The slave's cyc/stb drop combinationally with it, and a late ack in that cycle is discarded.
- With no grant, the `s_*` buses are 0 and `m_dat_o` is 0.

## Timing
- Reset values: `grant=0`, `last=NM-1`, state IDLE, `tcnt=0`. All `s_cyc_o`, `s_stb_o`, `m_ack_o` and `m_err_o` are 0.
- Arbitration latency: one cycle from `m_cyc_i` rising in IDLE to `s_stb_o`. Slave ack passes to the master with zero added latency.
- Back-to-back strobes within one held cyc incur no re-arbitration.
- Simultaneous requests in IDLE resolve round-robin. A master whose cyc falls in the arbitration cycle is not granted.
- Reset asserted mid-transaction: all outputs are 0 at the next edge.

## Structure
- Package `wb_bus_pkg` holds the state enum, default base/mask constants and the `TIMEOUT` counter width.
- Sub-module `wb_rr_arbiter` (parameter NM; inputs req, last; output one-hot grant) is instantiated once.

## Test plan
- Master 0 reads 0x8000_0010 and the RAM acks after 2 cycles with 0xDEADBEEF → `s_stb_o=3'b001` one cycle after cyc; `m_ack_o[0]` is asserted and `m_dat_o` reads 0xDEADBEEF.
- Masters 0 and 1 both raise cyc after reset → master 0 is granted first. When master 0 drops cyc while master 1 holds, master 1 is granted 2 cycles later.
- Master 1 writes 0xA5 to 0x2000_0000 with sel 4'b0001 → GPIO slave sees cyc/stb/we and dat 0xA5; `m_ack_o[1]` follows the GPIO ack.
- Access to 0x4000_0000 → no `s_cyc_o`; single `m_err_o` pulse the next cycle.
- With TIMEOUT=4, the UART never acks → `m_err_o` pulses after 4 stalled cycles, with `s_stb_o[1]` low that cycle.
- Reset asserted during a stalled RAM cycle → all `s_cyc_o`/`s_stb_o` are 0 next cycle; after release, master 0 wins arbitration.
